// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one shared UART TX FIFO.
// Define UART_ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int B         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_req0,
  input  logic         i_req1,
  input  logic [B-1:0] i_data0,
  input  logic [B-1:0] i_data1,
  input  logic         i_last0,
  input  logic         i_last1,
  output logic         o_ack0,
  output logic         o_ack1,
  input  logic         i_fifo_full,
  output logic         o_fifo_wr,
  output logic [B-1:0] o_fifo_wr_data,
  output logic [1:0]   o_grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_cfg
    $error("uart_tx_arbiter: MAX_BURST must be 1..255");
  end

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_last;
  logic           w_last_nxt;
  logic           w_own_req;
  logic           w_own_last;
  logic [B-1:0]   w_own_data;
  logic           w_acc;
  logic           w_wr;
  logic           w_limit;
  logic           w_end;

`ifdef UART_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_limit   = (w_cnt_inc == CW'(MAX_BURST));

  // Cleared on any state change, so every new grant starts at zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= w_cnt_inc;
    end
  end
`else
  assign w_limit = 1'b0;
`endif

  always_comb begin
    w_own_req  = 1'b0;
    w_own_last = 1'b0;
    w_own_data = '0;
    case (r_state)
      GRANT0: begin
        w_own_req  = i_req0;
        w_own_last = i_last0;
        w_own_data = i_data0;
      end
      GRANT1: begin
        w_own_req  = i_req1;
        w_own_last = i_last1;
        w_own_data = i_data1;
      end
      default: ;
    endcase
  end

  assign w_acc = w_own_req & ~i_fifo_full;
  assign w_end = (r_state != IDLE) &
                 (~w_own_req | (w_acc & (w_own_last | w_limit)));

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        // r_last=1 means requester 1 went last, so 0 wins a tie.
        if (i_req0 & (~i_req1 | r_last)) begin
          w_state_nxt = GRANT0;
        end else if (i_req1) begin
          w_state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        if (w_end) begin
          w_last_nxt  = 1'b0;
          w_state_nxt = i_req1 ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (w_end) begin
          w_last_nxt  = 1'b1;
          w_state_nxt = i_req0 ? GRANT0 : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign w_wr           = w_acc & ~i_reset;
  assign o_fifo_wr      = w_wr;
  assign o_fifo_wr_data = w_wr ? w_own_data : '0;
  assign o_ack0         = w_wr & (r_state == GRANT0);
  assign o_ack1         = w_wr & (r_state == GRANT1);
  assign o_grant        = {r_state == GRANT1, r_state == GRANT0};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter.
// Expectations follow UART_ARB_BURST_LIMIT_EN when it is defined.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] data0 = '0;
  logic [7:0] data1 = '0;
  logic       last0 = 1'b0;
  logic       last1 = 1'b0;
  logic       full = 1'b0;
  logic       ack0;
  logic       ack1;
  logic       wr;
  logic [7:0] wr_data;
  logic [1:0] grant;

  int n_chk = 0;
  int n_err = 0;
  int n_wr  = 0;

  uart_tx_arbiter #(.B(8), .MAX_BURST(4)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_req0         (req0),
    .i_req1         (req1),
    .i_data0        (data0),
    .i_data1        (data1),
    .i_last0        (last0),
    .i_last1        (last1),
    .o_ack0         (ack0),
    .o_ack1         (ack1),
    .i_fifo_full    (full),
    .o_fifo_wr      (wr),
    .o_fifo_wr_data (wr_data),
    .o_grant        (grant)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr === 1'b1) n_wr++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] g,
                         input logic w, input logic [7:0] d,
                         input logic a0, input logic a1);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".wr"}, 32'(wr), 32'(w));
    chk({tag, ".data"}, 32'(wr_data), 32'(d));
    chk({tag, ".ack0"}, 32'(ack0), 32'(a0));
    chk({tag, ".ack1"}, 32'(ack1), 32'(a1));
  endtask

  // Both requesters stream n bytes; records owner run lengths.
  task automatic stream(input int n);
    int i0 = 0;
    int i1 = 0;
    int cyc = 0;
    int own;
    int e0 = 0;
    int e1 = 0;
    int run_own[$];
    int run_len[$];
    int x_own[$];
    int x_len[$];
    logic a0;
    logic a1;
`ifdef UART_ARB_BURST_LIMIT_EN
    x_own = '{0, 1, 0, 1, 0, 1};
    x_len = '{4, 4, 4, 4, 2, 2};
`else
    x_own = '{0, 1};
    x_len = '{10, 10};
`endif
    while ((i0 < n || i1 < n) && cyc < 200) begin
      req0  = (i0 < n);
      data0 = 8'h40 + 8'(i0);
      last0 = (i0 == n - 1);
      req1  = (i1 < n);
      data1 = 8'h80 + 8'(i1);
      last1 = (i1 == n - 1);
      @(negedge clk);
      a0 = ack0;
      a1 = ack1;
      if (wr) begin
        own = (grant == 2'b10) ? 1 : 0;
        if (own == 0) begin
          chk("s.data0", 32'(wr_data), 32'(8'h40 + 8'(e0)));
          e0++;
        end else begin
          chk("s.data1", 32'(wr_data), 32'(8'h80 + 8'(e1)));
          e1++;
        end
        if (run_own.size() == 0 || run_own[$] != own) begin
          run_own.push_back(own);
          run_len.push_back(1);
        end else begin
          run_len[$] = run_len[$] + 1;
        end
      end
      tick();
      if (a0) i0++;
      if (a1) i1++;
      cyc++;
    end
    chk("s.done", 32'(cyc < 200), 32'd1);
    req0 = 1'b0; last0 = 1'b0;
    req1 = 1'b0; last1 = 1'b0;
    chk("s.nruns", 32'(run_len.size()), 32'(x_len.size()));
    for (int k = 0; k < x_len.size(); k++) begin
      if (k < run_len.size()) begin
        chk($sformatf("s.own%0d", k), 32'(run_own[k]), 32'(x_own[k]));
        chk($sformatf("s.len%0d", k), 32'(run_len[k]), 32'(x_len[k]));
      end
    end
    tick();
    @(negedge clk);
    chk_out("s.idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int w0;

    // Reset with both requests pending: all outputs low.
    req0 = 1'b1; data0 = 8'h11;
    req1 = 1'b1; data1 = 8'hA1; last1 = 1'b1;
    repeat (2) @(negedge clk);
    chk_out("rst", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Tie after reset: requester 0 first, then 1 with no IDLE gap.
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_out("t1.idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    chk_out("t1.b11", 2'b01, 1'b1, 8'h11, 1'b1, 1'b0);
    tick();
    data0 = 8'h22; last0 = 1'b1;
    @(negedge clk);
    chk_out("t1.b22", 2'b01, 1'b1, 8'h22, 1'b1, 1'b0);
    tick();
    req0 = 1'b0; last0 = 1'b0;
    @(negedge clk);
    chk_out("t1.g1", 2'b10, 1'b1, 8'hA1, 1'b0, 1'b1);
    tick();
    req1 = 1'b0; last1 = 1'b0;
    @(negedge clk);
    chk_out("t1.end", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Requester 1 stalls for 5 cycles on a full FIFO.
    w0 = n_wr;
    req1 = 1'b1; data1 = 8'h31;
    tick();
    @(negedge clk);
    chk_out("t2.b31", 2'b10, 1'b1, 8'h31, 1'b0, 1'b1);
    tick();
    data1 = 8'h32; full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_out($sformatf("t2.full%0d", k), 2'b10, 1'b0, 8'h00,
              1'b0, 1'b0);
      tick();
    end
    full = 1'b0;
    @(negedge clk);
    chk_out("t2.b32", 2'b10, 1'b1, 8'h32, 1'b0, 1'b1);
    tick();
    data1 = 8'h33; last1 = 1'b1;
    @(negedge clk);
    chk_out("t2.b33", 2'b10, 1'b1, 8'h33, 1'b0, 1'b1);
    tick();
    req1 = 1'b0; last1 = 1'b0;
    @(negedge clk);
    chk_out("t2.end", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2.nwr", 32'(n_wr - w0), 32'd3);

    // Both stream 10-byte bursts.
    tick();
    stream(10);

    // Reset in the middle of a 4-byte burst from requester 0.
    tick();
    req0 = 1'b1; data0 = 8'h61;
    tick();
    @(negedge clk);
    chk_out("t4.b61", 2'b01, 1'b1, 8'h61, 1'b1, 1'b0);
    tick();
    data0 = 8'h62;
    @(negedge clk);
    chk_out("t4.b62", 2'b01, 1'b1, 8'h62, 1'b1, 1'b0);
    tick();
    data0 = 8'h63;
    #2;
    rst = 1'b1;
    #1;
    chk_out("t4.async", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("t4.hold", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    req0 = 1'b0;
    req1 = 1'b1; data1 = 8'h71; last1 = 1'b1;
    @(negedge clk);
    chk_out("t4.idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    chk_out("t4.g1", 2'b10, 1'b1, 8'h71, 1'b0, 1'b1);
    tick();
    req1 = 1'b0; last1 = 1'b0;
    @(negedge clk);
    chk_out("t4.end", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Requester 0 drops early; next tie goes to requester 1.
    req0 = 1'b1; data0 = 8'h51;
    tick();
    @(negedge clk);
    chk_out("t5.b51", 2'b01, 1'b1, 8'h51, 1'b1, 1'b0);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk_out("t5.drop", 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    req0 = 1'b1; data0 = 8'h52; last0 = 1'b1;
    req1 = 1'b1; data1 = 8'h91; last1 = 1'b1;
    @(negedge clk);
    chk_out("t5.idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    chk_out("t5.rr", 2'b10, 1'b1, 8'h91, 1'b0, 1'b1);
    tick();
    req1 = 1'b0; last1 = 1'b0;
    @(negedge clk);
    chk_out("t5.g0", 2'b01, 1'b1, 8'h52, 1'b1, 1'b0);
    tick();
    req0 = 1'b0; last0 = 1'b0;
    @(negedge clk);
    chk_out("t5.end", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
